// File: rtl/cbf_counter_controller.sv
// cbf_counter_controller
//   Sequencer for a counting Bloom filter bank of CNT_W-bit saturating
//   counters (2**IDX_W entries). Accepts one request at a time carrying
//   NUM_HASH pre-hashed indices and walks them one read-modify-write per
//   cycle, index 0 first.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake; ready only while idle
//   req_op             00 query, 01 insert, 10 delete, 11 clear
//   req_idx            index h at [h*IDX_W +: IDX_W]
//   resp_valid         one-cycle response strobe
//   resp_hit           query: every addressed counter nonzero
//   resp_sat           insert: some addressed counter was saturated
//   resp_err           delete: rejected (zero/saturated) or underflowed
//   busy               controller not idle
module cbf_counter_controller #(
   parameter int NUM_HASH = 3,
   parameter int IDX_W    = 6,
   parameter int CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [1:0]                req_op,
   input  logic [NUM_HASH*IDX_W-1:0] req_idx,
   output logic                      resp_valid,
   output logic                      resp_hit,
   output logic                      resp_sat,
   output logic                      resp_err,
   output logic                      busy
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int HW    = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;

   localparam logic [1:0] OP_QUERY  = 2'b00;
   localparam logic [1:0] OP_INSERT = 2'b01;
   localparam logic [1:0] OP_DELETE = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_QUERY, S_INSERT, S_DCHECK, S_DAPPLY, S_CLEAR, S_RESP
   } state_t;

   state_t                    state, state_nxt;
   logic                      rdy_en;     // holds ready low until the first edge out of reset
   logic [1:0]                op_q;
   logic [NUM_HASH*IDX_W-1:0] idx_q;
   logic [HW-1:0]             h_q;
   logic                      hit_q, sat_q, err_q;
   logic [CNT_W-1:0]          cnt_mem [DEPTH];

   logic [IDX_W-1:0]          cur_idx;
   logic [CNT_W-1:0]          rd;
   logic                      rd_zero, rd_sat, last_step, accept;

   assign req_ready = rdy_en && (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign accept    = req_valid && req_ready;
   assign last_step = (h_q == HW'(NUM_HASH - 1));

   // select the index for the current step
   always_comb begin
      cur_idx = '0;
      for (int i = 0; i < NUM_HASH; i++)
         if (h_q == HW'(i)) cur_idx = idx_q[i*IDX_W +: IDX_W];
   end

   assign rd      = cnt_mem[cur_idx];
   assign rd_zero = (rd == '0);
   assign rd_sat  = &rd;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (req_op)
                  OP_QUERY:  state_nxt = S_QUERY;
                  OP_INSERT: state_nxt = S_INSERT;
                  OP_DELETE: state_nxt = S_DCHECK;
                  default:   state_nxt = S_CLEAR;
               endcase
            end
         end
         S_QUERY, S_INSERT, S_DAPPLY: if (last_step) state_nxt = S_RESP;
         // the last step's own check must count toward the apply decision
         S_DCHECK: if (last_step) state_nxt = (err_q || rd_zero || rd_sat) ? S_RESP : S_DAPPLY;
         S_CLEAR:  state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // datapath: request capture, step counter, accumulators, counter array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en     <= 1'b0;
         op_q       <= '0;
         idx_q      <= '0;
         h_q        <= '0;
         hit_q      <= 1'b0;
         sat_q      <= 1'b0;
         err_q      <= 1'b0;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_sat   <= 1'b0;
         resp_err   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) cnt_mem[i] <= '0;
      end else begin
         rdy_en     <= 1'b1;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_sat   <= 1'b0;
         resp_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q  <= req_op;
                  idx_q <= req_idx;
                  h_q   <= '0;
                  hit_q <= 1'b1;
                  sat_q <= 1'b0;
                  err_q <= 1'b0;
               end
            end
            S_QUERY: begin
               if (rd_zero) hit_q <= 1'b0;
               h_q <= last_step ? '0 : h_q + HW'(1);
            end
            S_INSERT: begin
               if (rd_sat) sat_q <= 1'b1;
               else        cnt_mem[cur_idx] <= rd + CNT_W'(1);
               h_q <= last_step ? '0 : h_q + HW'(1);
            end
            S_DCHECK: begin
               if (rd_zero || rd_sat) err_q <= 1'b1;
               h_q <= last_step ? '0 : h_q + HW'(1);
            end
            S_DAPPLY: begin
               // a repeated index can reach zero mid-request; floor it and
               // keep the decrements already applied. Saturated stays sticky.
               if (rd_zero || rd_sat) err_q <= 1'b1;
               else                   cnt_mem[cur_idx] <= rd - CNT_W'(1);
               h_q <= last_step ? '0 : h_q + HW'(1);
            end
            S_CLEAR: begin
               for (int i = 0; i < DEPTH; i++) cnt_mem[i] <= '0;
            end
            S_RESP: begin
               resp_valid <= 1'b1;
               resp_hit   <= (op_q == OP_QUERY)  && hit_q;
               resp_sat   <= (op_q == OP_INSERT) && sat_q;
               resp_err   <= (op_q == OP_DELETE) && err_q;
            end
            default: ;
         endcase
      end
   end

endmodule
